intersection_scheduler: RTL and testbench

- Right-of-way scheduler for a 4-approach intersection.
- Grants green to one phase at a time, round-robin among requesting approaches.
- Enforces minimum green, yellow and all-red intervals.
- Parks on a home phase when idle; supports emergency preemption.
- Drives the per-phase one-hot light encoding used by the lab traffic controllers: Red=001, Yellow=010, Green=100.

---
 rtl/intersection_scheduler.sv | 148 ++++++++++++++
 tb/tb_intersection_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/intersection_scheduler.sv
// Four-approach right-of-way scheduler: round-robin green grants with minimum
// green, yellow and all-red intervals, home-phase parking and emergency preemption.
module intersection_scheduler #(
    parameter int GREEN_MIN = 70,
    parameter int YELLOW_T  = 25,
    parameter int ALLRED_T  = 1,
    parameter int HOME      = 0,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic        emg,
    input  logic [1:0]  emg_phase,
    output logic [11:0] light,
    output logic [1:0]  cur_phase,
    output logic [1:0]  state,
    output logic        emg_active
);

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        ALLRED = 2'b10
    } phase_state_t;

    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] A_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [1:0]       HOME_P   = 2'(HOME);
    localparam logic [11:0]      HOME_LIGHT = 12'b001_001_001_001
                                            ^ (12'b101 << (3 * HOME));

    phase_state_t     state_q, state_n;
    logic [1:0]       cur_q, cur_n;
    logic [1:0]       target_q, target_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [11:0]      light_q, light_n;
    logic             emg_active_q, emg_active_n;
    logic [1:0]       cand, idx, tgt;
    logic             cand_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= GREEN;
            cur_q        <= HOME_P;
            target_q     <= HOME_P;
            cnt_q        <= CNT_ZERO;
            light_q      <= HOME_LIGHT;
            emg_active_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            cur_q        <= cur_n;
            target_q     <= target_n;
            cnt_q        <= cnt_n;
            light_q      <= light_n;
            emg_active_q <= emg_active_n;
        end
    end

    // Nearest requester after the current phase; scanning downward lets the closest one win.
    always_comb begin
        cand     = cur_q;
        cand_vld = 1'b0;
        idx      = cur_q;
        for (int k = 3; k >= 1; k--) begin
            idx = cur_q + 2'(k);
            if (req[idx]) begin
                cand     = idx;
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        cur_n    = cur_q;
        target_n = target_q;
        cnt_n    = cnt_q;
        tgt      = emg ? emg_phase : target_q;
        case (state_q)
            GREEN: begin
                cnt_n = (cnt_q == G_LAST) ? cnt_q : cnt_q + CNT_ONE;
                if (emg) begin
                    if (emg_phase != cur_q) begin
                        state_n  = YELLOW;
                        cnt_n    = CNT_ZERO;
                        target_n = emg_phase;
                    end
                end else if (cnt_q == G_LAST) begin
                    if (cand_vld) begin
                        state_n  = YELLOW;
                        cnt_n    = CNT_ZERO;
                        target_n = cand;
                    end else if (cur_q != HOME_P && !req[cur_q]) begin
                        state_n  = YELLOW;
                        cnt_n    = CNT_ZERO;
                        target_n = HOME_P;
                    end
                end
            end
            YELLOW: begin
                cnt_n    = cnt_q + CNT_ONE;
                target_n = tgt;
                if (cnt_q == Y_LAST) begin
                    state_n = ALLRED;
                    cnt_n   = CNT_ZERO;
                end
            end
            ALLRED: begin
                cnt_n    = cnt_q + CNT_ONE;
                target_n = tgt;
                if (cnt_q == A_LAST) begin
                    state_n = GREEN;
                    cnt_n   = CNT_ZERO;
                    cur_n   = tgt;
                end
            end
            default: begin
                state_n = GREEN;
                cnt_n   = CNT_ZERO;
            end
        endcase
    end

    // Lights are decoded from the next state so they are registered alongside it.
    always_comb begin
        light_n = 12'b001_001_001_001;
        for (int i = 0; i < 4; i++) begin
            if (cur_n == 2'(i)) begin
                case (state_n)
                    GREEN:   light_n[3*i +: 3] = 3'b100;
                    YELLOW:  light_n[3*i +: 3] = 3'b010;
                    default: light_n[3*i +: 3] = 3'b001;
                endcase
            end
        end
        emg_active_n = (state_n == GREEN) && (cur_n == emg_phase) && emg;
    end

    assign light      = light_q;
    assign cur_phase  = cur_q;
    assign state      = state_q;
    assign emg_active = emg_active_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed table-driven bench for intersection_scheduler with default parameters,
// plus hand-written reset-during-yellow/all-red sequences.
module tb_intersection_scheduler;

    localparam logic [11:0] L0G  = 12'b001_001_001_100;
    localparam logic [11:0] L0Y  = 12'b001_001_001_010;
    localparam logic [11:0] L1G  = 12'b001_001_100_001;
    localparam logic [11:0] L1Y  = 12'b001_001_010_001;
    localparam logic [11:0] L2G  = 12'b001_100_001_001;
    localparam logic [11:0] L2Y  = 12'b001_010_001_001;
    localparam logic [11:0] L3G  = 12'b100_001_001_001;
    localparam logic [11:0] L3Y  = 12'b010_001_001_001;
    localparam logic [11:0] ALLR = 12'b001_001_001_001;
    localparam logic [11:0] YMSK = 12'b010_010_010_010;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic        emg;
    logic [1:0]  emg_phase;
    logic [11:0] light;
    logic [1:0]  cur_phase;
    logic [1:0]  state;
    logic        emg_active;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic        emg;
        logic [1:0]  emg_phase;
        int          n;
        logic [11:0] light;
        logic [1:0]  state;
        logic [1:0]  cur;
        logic        ea;
    } vec_t;

    vec_t vecs[$];

    intersection_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .emg        (emg),
        .emg_phase  (emg_phase),
        .light      (light),
        .cur_phase  (cur_phase),
        .state      (state),
        .emg_active (emg_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cmp(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    endtask

    task automatic checkOutput(input string tag, input logic [11:0] el, input logic [1:0] es,
                               input logic [1:0] ec, input logic ea);
        cmp({tag, ".light"},      light,                el);
        cmp({tag, ".state"},      {10'b0, state},       {10'b0, es});
        cmp({tag, ".cur_phase"},  {10'b0, cur_phase},   {10'b0, ec});
        cmp({tag, ".emg_active"}, {11'b0, emg_active},  {11'b0, ea});
    endtask

    task automatic addVec(input logic r, input logic [3:0] q, input logic e, input logic [1:0] ep,
                          input int n, input logic [11:0] l, input logic [1:0] s,
                          input logic [1:0] c, input logic a);
        vec_t v;
        v.rst_n = r; v.req = q; v.emg = e; v.emg_phase = ep; v.n = n;
        v.light = l; v.state = s; v.cur = c; v.ea = a;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n     = v.rst_n;
        req       = v.req;
        emg       = v.emg;
        emg_phase = v.emg_phase;
        step(v.n);
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; emg = 1'b0; emg_phase = 2'd0;

        // Cycle numbers below count edges after the last reset edge.
        addVec(1, 4'b0100, 0, 0, 69, L0G,  2'b00, 2'd0, 0);  // c69 last green
        addVec(1, 4'b0100, 0, 0,  1, L0Y,  2'b01, 2'd0, 0);  // c70
        addVec(1, 4'b0100, 0, 0, 24, L0Y,  2'b01, 2'd0, 0);  // c94
        addVec(1, 4'b0100, 0, 0,  1, ALLR, 2'b10, 2'd0, 0);  // c95
        addVec(1, 4'b0100, 0, 0,  1, L2G,  2'b00, 2'd2, 0);  // c96
        addVec(1, 4'b0000, 0, 0, 69, L2G,  2'b00, 2'd2, 0);  // c165
        addVec(1, 4'b0000, 0, 0,  1, L2Y,  2'b01, 2'd2, 0);  // c166 park toward home
        addVec(1, 4'b0000, 0, 0, 25, ALLR, 2'b10, 2'd2, 0);  // c191
        addVec(1, 4'b0000, 0, 0,  1, L0G,  2'b00, 2'd0, 0);  // c192
        addVec(1, 4'b0000, 0, 0, 300, L0G, 2'b00, 2'd0, 0);  // idle at home
        addVec(0, 4'b0000, 0, 0,  1, L0G,  2'b00, 2'd0, 0);  // reset
        addVec(1, 4'b0010, 0, 0, 10, L0G,  2'b00, 2'd0, 0);  // c10, cnt=10
        addVec(1, 4'b0010, 1, 3,  1, L0Y,  2'b01, 2'd0, 0);  // c11 preempted
        addVec(1, 4'b0010, 1, 3, 24, L0Y,  2'b01, 2'd0, 0);  // c35
        addVec(1, 4'b0010, 1, 3,  1, ALLR, 2'b10, 2'd0, 0);  // c36
        addVec(1, 4'b0010, 1, 3,  1, L3G,  2'b00, 2'd3, 1);  // c37
        addVec(1, 4'b0010, 1, 3, 200, L3G, 2'b00, 2'd3, 1);  // held by emergency
        addVec(1, 4'b0010, 0, 3,  1, L3Y,  2'b01, 2'd3, 0);  // release -> yellow
        addVec(1, 4'b0010, 0, 3, 25, ALLR, 2'b10, 2'd3, 0);
        addVec(1, 4'b0010, 0, 3,  1, L1G,  2'b00, 2'd1, 0);  // phase1 granted
        addVec(1, 4'b1101, 0, 0, 69, L1G,  2'b00, 2'd1, 0);
        addVec(1, 4'b1101, 0, 0,  1, L1Y,  2'b01, 2'd1, 0);
        addVec(1, 4'b1101, 0, 0, 26, L2G,  2'b00, 2'd2, 0);
        addVec(1, 4'b1101, 0, 0, 69, L2G,  2'b00, 2'd2, 0);
        addVec(1, 4'b1101, 0, 0,  1, L2Y,  2'b01, 2'd2, 0);
        addVec(1, 4'b1101, 0, 0, 26, L3G,  2'b00, 2'd3, 0);
        addVec(1, 4'b1101, 0, 0, 70, L3Y,  2'b01, 2'd3, 0);
        addVec(1, 4'b1101, 0, 0, 26, L0G,  2'b00, 2'd0, 0);
        addVec(1, 4'b1101, 0, 0, 70, L0Y,  2'b01, 2'd0, 0);
        addVec(1, 4'b1101, 0, 0, 26, L2G,  2'b00, 2'd2, 0);  // req[1]=0, skips to 2

        step(1);
        for (int c = 0; c < 500; c++) begin
            step(1);
            if (c % 50 == 0) checkOutput($sformatf("reset%0d", c), L0G, 2'b00, 2'd0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), vecs[i].light, vecs[i].state, vecs[i].cur, vecs[i].ea);
        end

        // Reset asserted in the middle of yellow.
        step(70);
        checkOutput("midY.pre", L2Y, 2'b01, 2'd2, 1'b0);
        step(5);
        rst_n = 1'b0;
        step(1);
        checkOutput("midY.rst", L0G, 2'b00, 2'd0, 1'b0);
        rst_n = 1'b1;
        req   = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            step(1);
            cmp($sformatf("midY.noyel%0d", c), light & YMSK, 12'b0);
            cmp($sformatf("midY.light%0d", c), light, L0G);
        end

        // Reset asserted during all-red.
        step(90);
        checkOutput("midA.pre", ALLR, 2'b10, 2'd0, 1'b0);
        rst_n = 1'b0;
        step(1);
        checkOutput("midA.rst", L0G, 2'b00, 2'd0, 1'b0);
        rst_n = 1'b1;
        step(1);
        checkOutput("midA.post", L0G, 2'b00, 2'd0, 1'b0);
        cmp("midA.noyel", light & YMSK, 12'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
